// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_ctrl_pkg;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  localparam u64 PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DISCARD
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps one bus request in flight,
// holds its output slot under stall and drops wrong-path responses after a redirect.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        ivalid,
  output logic [31:0] raw_instr,
  output logic [63:0] pc
);

  ifetch_state_t state_q, state_d;
  u64            pc_q, pc_d;
  u64            stale_q, stale_d;
  logic          ivalid_q, ivalid_d;
  u32            raw_instr_q, raw_instr_d;
  u64            pc_out_q, pc_out_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    ivalid_d    = ivalid_q;
    raw_instr_d = raw_instr_q;
    pc_out_d    = pc_out_q;
    case (state_q)
      REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Without a response the old request is still on the bus and must be drained.
          if (!iresp_data_ok) begin
            stale_d = pc_q;
            state_d = DISCARD;
          end
        end else if (iresp_data_ok) begin
          raw_instr_d = iresp_data;
          pc_out_d    = pc_q;
          ivalid_d    = 1'b1;
          pc_d        = pc_q + 64'd4;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          ivalid_d = 1'b0;
          pc_d     = redirect_pc;
          state_d  = REQ;
        end else if (!stall) begin
          ivalid_d = 1'b0;
          state_d  = REQ;
        end
      end
      DISCARD: begin
        if (redirect) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      stale_q     <= '0;
      ivalid_q    <= 1'b0;
      raw_instr_q <= '0;
      pc_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stale_q     <= stale_d;
      ivalid_q    <= ivalid_d;
      raw_instr_q <= raw_instr_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign ireq_valid = (state_q != HOLD);
  assign ireq_addr  = (state_q == DISCARD) ? stale_q : pc_q;
  assign ivalid     = ivalid_q;
  assign raw_instr  = raw_instr_q;
  assign pc         = pc_out_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus a randomized run,
// all compared against a transaction-level reference model.
module tb_ifetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ivalid;
  logic [31:0] raw_instr;
  logic [63:0] pc;

  int unsigned checks;
  int unsigned failures;

  ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ivalid       (ivalid),
    .raw_instr    (raw_instr),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a slot (full/empty), the address of the request in flight,
  // whether that request is wrong-path, and the next sequential fetch address.
  logic        m_slot;
  logic        m_wrong;
  logic [63:0] m_req;
  logic [63:0] m_next;
  logic [31:0] m_instr;
  logic [63:0] m_pc;

  task automatic model_reset();
    m_slot  = 1'b0;
    m_wrong = 1'b0;
    m_req   = RST_PC;
    m_next  = RST_PC;
    m_instr = '0;
    m_pc    = '0;
  endtask

  task automatic model_tick();
    if (m_slot) begin
      if (redirect) begin
        m_slot = 1'b0;
        m_next = redirect_pc;
        m_req  = redirect_pc;
      end else if (!stall) begin
        m_slot = 1'b0;
        m_req  = m_next;
      end
    end else if (iresp_data_ok) begin
      if (m_wrong || redirect) begin
        m_wrong = 1'b0;
        if (redirect) m_next = redirect_pc;
        m_req = m_next;
      end else begin
        m_slot  = 1'b1;
        m_instr = iresp_data;
        m_pc    = m_req;
        m_next  = m_req + 64'd4;
      end
    end else if (redirect) begin
      m_wrong = 1'b1;
      m_next  = redirect_pc;
    end
  endtask

  // Request address only matters while a request is presented.
  function automatic logic [161:0] model_vec();
    return {~m_slot, (m_slot ? 64'd0 : m_req), m_slot, m_instr, m_pc};
  endfunction

  function automatic logic [161:0] dut_vec();
    return {ireq_valid, (ireq_valid ? ireq_addr : 64'd0), ivalid, raw_instr, pc};
  endfunction

  // Apply one cycle of inputs (from a negedge), advance the model at the posedge.
  task automatic drive(input logic dok, input logic [31:0] d, input logic st,
                       input logic rd, input logic [63:0] rp);
    iresp_data_ok = dok;
    iresp_data    = d;
    stall         = st;
    redirect      = rd;
    redirect_pc   = rp;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    iresp_data_ok = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ireq_valid, ireq_addr, ivalid, raw_instr, pc} !== {1'b1, RST_PC, 1'b0, 32'd0, 64'd0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {ireq_valid, ireq_addr, ivalid, raw_instr, pc},
               {1'b1, RST_PC, 1'b0, 32'd0, 64'd0});
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_addr;
    logic [31:0] d;
    do_reset();
    exp_addr = RST_PC;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!(ireq_valid === 1'b1 && ireq_addr === exp_addr && ivalid === 1'b0)) begin
        failures++;
        $display("FAIL seq_req k=%0d got v=%b a=%h iv=%b exp v=1 a=%h iv=0",
                 k, ireq_valid, ireq_addr, ivalid, exp_addr);
      end
      d = $urandom;
      drive(1'b1, d, 1'b0, 1'b0, '0);
      checks++;
      if (!(ivalid === 1'b1 && pc === exp_addr && raw_instr === d && ireq_valid === 1'b0)) begin
        failures++;
        $display("FAIL seq_out k=%0d got iv=%b pc=%h ri=%h rv=%b exp iv=1 pc=%h ri=%h rv=0",
                 k, ivalid, pc, raw_instr, ireq_valid, exp_addr, d);
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      exp_addr = exp_addr + 64'd4;
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    d = $urandom;
    drive(1'b1, d, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!(ivalid === 1'b1 && pc === 64'h8000_0004 && raw_instr === d && ireq_valid === 1'b0)) begin
        failures++;
        $display("FAIL stall_hold k=%0d got iv=%b pc=%h ri=%h rv=%b exp iv=1 pc=80000004 ri=%h rv=0",
                 k, ivalid, pc, raw_instr, ireq_valid, d);
      end
      drive(1'b0, '0, (k < 3), 1'b0, '0);
    end
    checks++;
    if (!(ireq_valid === 1'b1 && ireq_addr === 64'h8000_0008 && ivalid === 1'b0)) begin
      failures++;
      $display("FAIL stall_next got v=%b a=%h iv=%b exp v=1 a=80000008 iv=0",
               ireq_valid, ireq_addr, ivalid);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b1, 64'h8000_1000);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!(ireq_valid === 1'b1 && ireq_addr === RST_PC && ivalid === 1'b0)) begin
        failures++;
        $display("FAIL redir_wait k=%0d got v=%b a=%h iv=%b exp v=1 a=%h iv=0",
                 k, ireq_valid, ireq_addr, ivalid, RST_PC);
      end
      drive((k == 2), $urandom, 1'b0, 1'b0, '0);
    end
    checks++;
    if (!(ireq_valid === 1'b1 && ireq_addr === 64'h8000_1000 && ivalid === 1'b0)) begin
      failures++;
      $display("FAIL redir_wait_next got v=%b a=%h iv=%b exp v=1 a=80001000 iv=0",
               ireq_valid, ireq_addr, ivalid);
    end
  endtask

  task automatic test_redirect_dataok();
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b1, 64'h8000_2000);
    checks++;
    if (!(ireq_valid === 1'b1 && ireq_addr === 64'h8000_2000 && ivalid === 1'b0)) begin
      failures++;
      $display("FAIL redir_dok got v=%b a=%h iv=%b exp v=1 a=80002000 iv=0",
               ireq_valid, ireq_addr, ivalid);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 1'b1, 64'h8000_3002);
    checks++;
    if (!(ivalid === 1'b0 && ireq_valid === 1'b1 && ireq_addr === 64'h8000_3002)) begin
      failures++;
      $display("FAIL redir_hold got iv=%b v=%b a=%h exp iv=0 v=1 a=80003002",
               ivalid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b1, 64'h0000_0040);
    drive(1'b1, $urandom, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hdead_beef, 1'b0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (!(ivalid === 1'b0 && pc === 64'd0 && raw_instr === 32'd0 && ireq_valid === 1'b1 &&
          ireq_addr === RST_PC)) begin
      failures++;
      $display("FAIL reset_mid got iv=%b pc=%h ri=%h v=%b a=%h exp iv=0 pc=0 ri=0 v=1 a=%h",
               ivalid, pc, raw_instr, ireq_valid, ireq_addr, RST_PC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (!(ireq_valid === 1'b1 && ireq_addr === RST_PC)) begin
      failures++;
      $display("FAIL reset_mid_release got v=%b a=%h exp v=1 a=%h", ireq_valid, ireq_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    int unsigned bad;
    logic [63:0] rp;
    do_reset();
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      rp = {$urandom, $urandom};
      drive(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), rp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_dataok();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
